// File: rtl/i2s_serializer_tx.sv
// I2S master transmitter: derives sclk/lrclk/sdout from a free-running 256*fs frame
// counter and serializes stereo pairs taken from a one-pair valid/ready holding buffer.
module i2s_serializer_tx #(
  parameter int audio_width = 16
) (
  input  logic                   clk256,
  input  logic                   reset,
  input  logic [audio_width-1:0] in_left,
  input  logic [audio_width-1:0] in_right,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   sclk,
  output logic                   lrclk,
  output logic                   sdout,
  output logic                   underrun
);

  logic [7:0]             cnt_q, cnt_d;
  logic                   full_q, full_d;
  logic [audio_width-1:0] buf_l_q, buf_l_d;
  logic [audio_width-1:0] buf_r_q, buf_r_d;
  logic [audio_width-1:0] word_l_q, word_l_d;
  logic [audio_width-1:0] word_r_q, word_r_d;
  logic                   ready_q, ready_d;
  logic                   sclk_q, sclk_d;
  logic                   lrclk_q, lrclk_d;
  logic                   sdout_q, sdout_d;
  logic                   underrun_q, underrun_d;

  logic [4:0]             slot;
  logic [audio_width-1:0] word;
  logic [audio_width-1:0] word_shifted;

  // Outputs are registered from the next count so each equals a function of the current cnt.
  always_comb begin
    cnt_d        = cnt_q + 8'd1;
    full_d       = full_q;
    buf_l_d      = buf_l_q;
    buf_r_d      = buf_r_q;
    word_l_d     = word_l_q;
    word_r_d     = word_r_q;
    underrun_d   = 1'b0;
    sdout_d      = 1'b0;
    word_shifted = '0;

    if (cnt_q == 8'hFF) begin
      if (full_q) begin
        word_l_d = buf_l_q;
        word_r_d = buf_r_q;
        full_d   = 1'b0;
      end else begin
        word_l_d   = '0;
        word_r_d   = '0;
        underrun_d = 1'b1;
      end
    end

    // A full buffer holds ready low, so an accept never collides with the frame transfer.
    if (in_valid && ready_q) begin
      buf_l_d = in_left;
      buf_r_d = in_right;
      full_d  = 1'b1;
    end

    ready_d = !full_d;
    sclk_d  = cnt_d[1];
    lrclk_d = cnt_d[7];
    slot    = cnt_d[6:2];
    word    = cnt_d[7] ? word_r_d : word_l_d;

    // Slot 0 carries the one-bit I2S delay; slots past the word length pad with zero.
    if (slot != 5'd0 && int'(slot) <= audio_width) begin
      word_shifted = word >> (audio_width - int'(slot));
      sdout_d      = word_shifted[0];
    end
  end

  always_ff @(posedge clk256 or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      full_q     <= 1'b0;
      buf_l_q    <= '0;
      buf_r_q    <= '0;
      word_l_q   <= '0;
      word_r_q   <= '0;
      ready_q    <= 1'b0;
      sclk_q     <= 1'b0;
      lrclk_q    <= 1'b0;
      sdout_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      full_q     <= full_d;
      buf_l_q    <= buf_l_d;
      buf_r_q    <= buf_r_d;
      word_l_q   <= word_l_d;
      word_r_q   <= word_r_d;
      ready_q    <= ready_d;
      sclk_q     <= sclk_d;
      lrclk_q    <= lrclk_d;
      sdout_q    <= sdout_d;
      underrun_q <= underrun_d;
    end
  end

  assign in_ready = ready_q;
  assign sclk     = sclk_q;
  assign lrclk    = lrclk_q;
  assign sdout    = sdout_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_serializer_tx.sv
// Bench for i2s_serializer_tx: an independent frame counter and I2S receiver decode each
// frame, and accepted pairs are scoreboarded against the frame that should carry them.
module tb_i2s_serializer_tx;

  localparam int W = 16;

  logic         clk256 = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] inLeft = '0;
  logic [W-1:0] inRight = '0;
  logic         inValid = 1'b0;
  logic         inReady;
  logic         sclk;
  logic         lrclk;
  logic         sdout;
  logic         underrun;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [W-1:0] l;
    logic [W-1:0] r;
    logic         extra;
    logic         uAt0;
    int           uOther;
    int           frameNo;
  } rxRec_t;

  typedef struct {
    logic [W-1:0] l;
    logic [W-1:0] r;
    int           frameNo;
  } exp_t;

  rxRec_t rxQ[$];
  exp_t   expQ[$];

  logic [7:0]  benchCnt;
  int          frameCount;
  logic [63:0] rxBits;
  logic        rxU0;
  int          rxUOther;

  i2s_serializer_tx #(.audio_width(W)) dut (
    .clk256   (clk256),
    .reset    (reset),
    .in_left  (inLeft),
    .in_right (inRight),
    .in_valid (inValid),
    .in_ready (inReady),
    .sclk     (sclk),
    .lrclk    (lrclk),
    .sdout    (sdout),
    .underrun (underrun)
  );

  always #5 clk256 = ~clk256;

  always @(posedge clk256 or posedge reset) begin
    if (reset) benchCnt <= 8'd0;
    else       benchCnt <= benchCnt + 8'd1;
  end

  function automatic rxRec_t buildRec();
    rxRec_t rec;
    rec.extra = 1'b0;
    for (int i = 0; i < W; i++) begin
      rec.l[W-1-i] = rxBits[1+i];
      rec.r[W-1-i] = rxBits[33+i];
    end
    for (int s = 0; s < 32; s++)
      if (s == 0 || s > W) rec.extra = rec.extra | rxBits[s] | rxBits[32+s];
    rec.uAt0    = rxU0;
    rec.uOther  = rxUOther + ((underrun === 1'b1) ? 1 : 0);
    rec.frameNo = frameCount;
    return rec;
  endfunction

  // Receiver samples sdout on the first high cycle of sclk, i.e. at the sclk rising edge.
  always @(negedge clk256) begin
    if (reset) begin
      frameCount <= 0;
      rxUOther   <= 0;
    end else begin
      if (benchCnt[1:0] == 2'd2) rxBits[benchCnt[7:2]] <= sdout;
      if (benchCnt == 8'd0) begin
        rxU0     <= underrun;
        rxUOther <= 0;
      end else if (underrun === 1'b1) begin
        rxUOther <= rxUOther + 1;
      end
      if (benchCnt == 8'hFF) begin
        rxQ.push_back(buildRec());
        frameCount <= frameCount + 1;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitCnt(input logic [7:0] target, input string tag);
    int n = 0;
    while (benchCnt !== target && n < 600) begin
      @(negedge clk256);
      n++;
    end
    compared++;
    if (benchCnt !== target) begin
      mismatched++;
      $display("[TB] FAIL %s wait: cnt=%0d required=%0d", tag, benchCnt, target);
    end
  endtask

  task automatic offerPair(input logic [W-1:0] l, input logic [W-1:0] r, input string tag,
                           output logic [7:0] acceptCnt);
    int n = 0;
    int frame;
    inLeft  = l;
    inRight = r;
    inValid = 1'b1;
    while (inReady !== 1'b1 && n < 600) begin
      @(negedge clk256);
      n++;
    end
    compared++;
    if (inReady !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL %s accept: in_ready=%b required=1", tag, inReady);
      inValid   = 1'b0;
      acceptCnt = 8'hFF;
      return;
    end
    acceptCnt = benchCnt;
    frame     = frameCount;
    @(posedge clk256);
    expQ.push_back('{l, r, frame + 1});
    @(negedge clk256);
    inValid = 1'b0;
  endtask

  task automatic getFrame(input int target, output rxRec_t rec, output bit found);
    found = 0;
    for (int i = 0; i < 1200 && !found; i++) begin
      while (rxQ.size() > 0 && rxQ[0].frameNo < target) void'(rxQ.pop_front());
      if (rxQ.size() > 0 && rxQ[0].frameNo == target) begin
        rec   = rxQ.pop_front();
        found = 1;
      end else begin
        @(negedge clk256);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk256);
    compared++;
    if ({sclk, lrclk, sdout, inReady, underrun} !== 5'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got %b required 00000",
               {sclk, lrclk, sdout, inReady, underrun});
    end
    reset = 1'b0;
    compared++;
    if (inReady !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_ready_release: in_ready=%b required=0", inReady);
    end
    @(negedge clk256);
    compared++;
    if (inReady !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_ready_rise: in_ready=%b required=1", inReady);
    end
  endtask

  task automatic test_idle();
    waitCnt(8'd0, "idle");
    for (int i = 0; i < 512; i++) begin
      compared += 4;
      if (sclk !== benchCnt[1]) begin
        mismatched++;
        $display("[TB] FAIL idle_sclk cnt=%0d: got %b required %b", benchCnt, sclk, benchCnt[1]);
      end
      if (lrclk !== benchCnt[7]) begin
        mismatched++;
        $display("[TB] FAIL idle_lrclk cnt=%0d: got %b required %b", benchCnt, lrclk, benchCnt[7]);
      end
      if (sdout !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL idle_sdout cnt=%0d: got %b required 0", benchCnt, sdout);
      end
      if (underrun !== (benchCnt == 8'd0)) begin
        mismatched++;
        $display("[TB] FAIL idle_underrun cnt=%0d: got %b required %b", benchCnt, underrun,
                 benchCnt == 8'd0);
      end
      @(negedge clk256);
    end
  endtask

  task automatic test_pair(input logic [W-1:0] l, input logic [W-1:0] r, input string tag);
    logic [7:0] acc;
    exp_t       e;
    rxRec_t     rec;
    bit         found;
    waitCnt(8'd0, tag);
    offerPair(l, r, tag, acc);
    e = expQ.pop_front();
    getFrame(e.frameNo, rec, found);
    compared += 3;
    if (!found || {rec.l, rec.r} !== {e.l, e.r}) begin
      mismatched++;
      $display("[TB] FAIL %s data: got L=%h R=%h required L=%h R=%h", tag, rec.l, rec.r, e.l, e.r);
    end
    if (!found || rec.extra !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL %s pad_slots: got %b required 0", tag, rec.extra);
    end
    if (!found || rec.uAt0 !== 1'b0 || rec.uOther != 0) begin
      mismatched++;
      $display("[TB] FAIL %s underrun: got %b/%0d required 0/0", tag, rec.uAt0, rec.uOther);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] acc1, acc2;
    exp_t       e;
    rxRec_t     rec;
    bit         found;
    waitCnt(8'd0, "b2b");
    offerPair(16'h1234, 16'hFEDC, "b2b_p1", acc1);
    compared++;
    if (inReady !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL b2b_ready_low: in_ready=%b required=0", inReady);
    end
    offerPair(16'h5A5A, 16'hC3C3, "b2b_p2", acc2);
    compared++;
    if (acc2 !== 8'd0) begin
      mismatched++;
      $display("[TB] FAIL b2b_p2_accept_cnt: got %0d required 0", acc2);
    end
    for (int k = 0; k < 2; k++) begin
      e = expQ.pop_front();
      getFrame(e.frameNo, rec, found);
      compared += 2;
      if (!found || {rec.l, rec.r, rec.extra} !== {e.l, e.r, 1'b0}) begin
        mismatched++;
        $display("[TB] FAIL b2b_frame%0d data: got L=%h R=%h x=%b required L=%h R=%h x=0",
                 k, rec.l, rec.r, rec.extra, e.l, e.r);
      end
      if (!found || rec.uAt0 !== 1'b0 || rec.uOther != 0) begin
        mismatched++;
        $display("[TB] FAIL b2b_frame%0d underrun: got %b/%0d required 0/0", k, rec.uAt0, rec.uOther);
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] acc;
    exp_t       e1, e3;
    rxRec_t     rec;
    bit         found;
    waitCnt(8'd0, "stall");
    offerPair(16'h0F0F, 16'hF00F, "stall_p1", acc);
    waitCnt(8'd0, "stall_f1");
    @(negedge clk256);
    waitCnt(8'd0, "stall_f2");
    offerPair(16'h7E81, 16'h8001, "stall_p3", acc);
    e1 = expQ.pop_front();
    e3 = expQ.pop_front();
    getFrame(e1.frameNo, rec, found);
    compared++;
    if (!found || {rec.l, rec.r, rec.extra, rec.uAt0} !== {e1.l, e1.r, 2'b00}) begin
      mismatched++;
      $display("[TB] FAIL stall_p1: got L=%h R=%h x=%b u=%b required L=%h R=%h x=0 u=0",
               rec.l, rec.r, rec.extra, rec.uAt0, e1.l, e1.r);
    end
    getFrame(e1.frameNo + 1, rec, found);
    compared += 2;
    if (!found || {rec.l, rec.r, rec.extra} !== '0) begin
      mismatched++;
      $display("[TB] FAIL stall_silence: got L=%h R=%h x=%b required all 0", rec.l, rec.r, rec.extra);
    end
    if (!found || rec.uAt0 !== 1'b1 || rec.uOther != 0) begin
      mismatched++;
      $display("[TB] FAIL stall_underrun: got %b/%0d required 1/0", rec.uAt0, rec.uOther);
    end
    getFrame(e3.frameNo, rec, found);
    compared++;
    if (!found || {rec.l, rec.r, rec.extra, rec.uAt0} !== {e3.l, e3.r, 2'b00}) begin
      mismatched++;
      $display("[TB] FAIL stall_resume: got L=%h R=%h x=%b u=%b required L=%h R=%h x=0 u=0",
               rec.l, rec.r, rec.extra, rec.uAt0, e3.l, e3.r);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] acc;
    rxRec_t     rec;
    bit         found;
    waitCnt(8'd0, "midrst");
    offerPair(16'hBEEF, 16'hCAFE, "midrst_pair", acc);
    waitCnt(8'd70, "midrst_cnt70");
    reset = 1'b1;
    #1;
    compared++;
    if ({sclk, lrclk, sdout, inReady, underrun} !== 5'b0) begin
      mismatched++;
      $display("[TB] FAIL midrst_async: got %b required 00000", {sclk, lrclk, sdout, inReady, underrun});
    end
    expQ.delete();
    repeat (2) @(negedge clk256);
    reset = 1'b0;
    rxQ.delete();
    @(negedge clk256);
    compared++;
    if (inReady !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL midrst_ready: in_ready=%b required=1", inReady);
    end
    getFrame(0, rec, found);
    compared++;
    if (!found || {rec.l, rec.r, rec.extra, rec.uAt0} !== '0) begin
      mismatched++;
      $display("[TB] FAIL midrst_frame0: got L=%h R=%h x=%b u=%b required all 0",
               rec.l, rec.r, rec.extra, rec.uAt0);
    end
    getFrame(1, rec, found);
    compared++;
    if (!found || {rec.l, rec.r, rec.extra, rec.uAt0} !== {{(2*W+1){1'b0}}, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL midrst_frame1: got L=%h R=%h x=%b u=%b required L=0 R=0 x=0 u=1",
               rec.l, rec.r, rec.extra, rec.uAt0);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_pair(16'hA5F0, 16'h0001, "basic");
    test_pair(16'h8000, 16'h7FFF, "sign");
    test_back_to_back();
    test_stall();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
